// File: rtl/load_store_unit_pkg.sv
// Shared LSU types and RV32I load/store funct3 codes.
// Imported by the aligner and the LSU top.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/load_store_unit_data_align.sv
// Byte-lane steering, load extension and legality.
// Purely combinational; shared by issue and completion.
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_rd_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_lane_data,
    output logic [31:0] o_ld_data,
    output logic        o_legal
);

    logic [31:0] w_shift;

    assign w_shift = i_rd_word >> {i_addr, 3'b000};

    // Lane pattern and replicated store data
    always_comb begin
        o_byte_en   = 4'b0000;
        o_lane_data = i_wr_data;
        case (i_funct3)
            F3_SB, F3_LBU: begin
                o_byte_en   = 4'b0001 << i_addr;
                o_lane_data = {4{i_wr_data[7:0]}};
            end
            F3_SH, F3_LHU: begin
                o_byte_en   = 4'b0011 << {i_addr[1], 1'b0};
                o_lane_data = {2{i_wr_data[15:0]}};
            end
            F3_SW: o_byte_en = 4'b1111;
            default: o_byte_en = 4'b0000;
        endcase
    end

    // Load extension and access legality
    always_comb begin
        o_ld_data = 32'h0;
        o_legal   = 1'b0;
        case (i_funct3)
            F3_LB: begin
                o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
                o_legal   = 1'b1;
            end
            F3_LBU: begin
                o_ld_data = {24'h0, w_shift[7:0]};
                o_legal   = !i_we;
            end
            F3_LH: begin
                o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
                o_legal   = !i_addr[0];
            end
            F3_LHU: begin
                o_ld_data = {16'h0, w_shift[15:0]};
                o_legal   = !i_we && !i_addr[0];
            end
            F3_LW: begin
                o_ld_data = w_shift;
                o_legal   = (i_addr == 2'b00);
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one aligned bus word per request,
// stalling the core until DONE, with fault/timeout flags.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWrData,
    output logic [31:0] oRdData,
    output logic        oStall,
    output logic        oMisalign,
    output logic        oBusErr,
    output logic        oBus_Valid,
    input  logic        iBus_Ready,
    output logic [31:0] oBus_Addr,
    output logic        oBus_WrEn,
    output logic [3:0]  oBus_ByteEn,
    output logic [31:0] oBus_WrData,
    input  logic [31:0] iBus_RdData
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

    lsu_state_t  r_state;
    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [3:0]  r_ben;
    logic [31:0] r_lane;
    logic [31:0] r_rddata;
    logic        r_misalign;
    logic        r_buserr;
    logic [CW-1:0] r_cnt;

    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic        w_we;
    logic [3:0]  w_ben;
    logic [31:0] w_lane;
    logic [31:0] w_ld;
    logic        w_legal;

    // Live request in IDLE, latched request once issued
    assign w_f3  = (r_state == IDLE) ? iFunct3 : r_funct3;
    assign w_off = (r_state == IDLE) ? iAddr[1:0] : r_addr[1:0];
    assign w_we  = (r_state == IDLE) ? iWe : r_we;

    lsu_data_align u_align (
        .i_funct3    (w_f3),
        .i_we        (w_we),
        .i_addr      (w_off),
        .i_wr_data   (iWrData),
        .i_rd_word   (iBus_RdData),
        .o_byte_en   (w_ben),
        .o_lane_data (w_lane),
        .o_ld_data   (w_ld),
        .o_legal     (w_legal)
    );

    assign oStall      = iRst_n & iReq & (r_state != DONE);
    assign oBus_Valid  = (r_state == ACCESS);
    assign oBus_Addr   = {r_addr[31:2], 2'b00};
    assign oBus_WrEn   = r_we;
    assign oBus_ByteEn = r_ben;
    assign oBus_WrData = r_lane;
    assign oRdData     = r_rddata;
    assign oMisalign   = r_misalign;
    assign oBusErr     = r_buserr;

    // FSM, request latches, timeout counter, result pulses
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state    <= IDLE;
            r_addr     <= 32'h0;
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_ben      <= 4'b0000;
            r_lane     <= 32'h0;
            r_rddata   <= 32'h0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_rddata   <= 32'h0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iReq && w_legal) begin
                        r_state  <= ACCESS;
                        r_addr   <= iAddr;
                        r_we     <= iWe;
                        r_funct3 <= iFunct3;
                        r_ben    <= w_ben;
                        r_lane   <= w_lane;
                        r_cnt    <= '0;
                    end else if (iReq) begin
                        r_state    <= DONE;
                        r_misalign <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (iBus_Ready) begin
                        r_state <= DONE;
                        if (!r_we) r_rddata <= w_ld;
                    end else if (r_cnt == LIM) begin
                        r_state  <= DONE;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: drives requests,
// plays a bus slave, compares results at DONE.
module tb_load_store_unit;

    localparam int TO = 16;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        berr;
        int          cyc;
        int          vc;
    } exp_t;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iReq = 1'b0;
    logic        iWe = 1'b0;
    logic [2:0]  iFunct3 = 3'b000;
    logic [31:0] iAddr = 32'h0;
    logic [31:0] iWrData = 32'h0;
    logic [31:0] oRdData;
    logic        oStall;
    logic        oMisalign;
    logic        oBusErr;
    logic        oBus_Valid;
    logic        iBus_Ready = 1'b0;
    logic [31:0] oBus_Addr;
    logic        oBus_WrEn;
    logic [3:0]  oBus_ByteEn;
    logic [31:0] oBus_WrData;
    logic [31:0] iBus_RdData = 32'h0;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 iClk = ~iClk;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iReq        (iReq),
        .iWe         (iWe),
        .iFunct3     (iFunct3),
        .iAddr       (iAddr),
        .iWrData     (iWrData),
        .oRdData     (oRdData),
        .oStall      (oStall),
        .oMisalign   (oMisalign),
        .oBusErr     (oBusErr),
        .oBus_Valid  (oBus_Valid),
        .iBus_Ready  (iBus_Ready),
        .oBus_Addr   (oBus_Addr),
        .oBus_WrEn   (oBus_WrEn),
        .oBus_ByteEn (oBus_ByteEn),
        .oBus_WrData (oBus_WrData),
        .iBus_RdData (iBus_RdData)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic legal_m(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
        case (f3)
            3'b000:  return 1'b1;
            3'b100:  return !we;
            3'b001:  return !a[0];
            3'b101:  return !we && !a[0];
            3'b010:  return a == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int nb_m(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ben_m(input logic [2:0] f3,
                                         input logic [1:0] a);
        logic [3:0] b;
        int nb;
        int off;
        nb  = nb_m(f3);
        off = (nb == 4) ? 0 : (nb == 2) ? int'({a[1], 1'b0}) : int'(a);
        for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + nb);
        return b;
    endfunction

    function automatic logic [31:0] lane_m(input logic [2:0] f3,
                                           input logic [31:0] wd);
        logic [31:0] l;
        int nb;
        nb = nb_m(f3);
        for (int i = 0; i < 4; i++) l[8*i +: 8] = wd[8*(i % nb) +: 8];
        return l;
    endfunction

    // dly < 0 means the slave never answers
    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rw, input int dly,
                       input logic [31:0] exp_rd);
        exp_t e;
        exp_t g;
        logic lg;
        int   n;
        int   vc;
        bit   done;
        lg     = legal_m(we, f3, a[1:0]);
        e.rd   = (lg && !we && dly >= 0) ? exp_rd : 32'h0;
        e.mis  = !lg;
        e.berr = lg && (dly < 0);
        e.cyc  = !lg ? 2 : (dly < 0) ? 2 + TO : 3 + dly;
        e.vc   = !lg ? 0 : (dly < 0) ? TO : dly + 1;
        sb.push_back(e);
        @(negedge iClk);
        iReq = 1'b1; iWe = we; iFunct3 = f3; iAddr = a; iWrData = wd;
        iBus_Ready = 1'b0;
        #1;
        chk("idle_valid", {31'h0, oBus_Valid}, 32'h0);
        chk("idle_stall", {31'h0, oStall}, 32'h1);
        chk("idle_pulse", {30'h0, oMisalign, oBusErr}, 32'h0);
        n = 1; vc = 0; done = 0;
        while (!done && n < 64) begin
            @(negedge iClk);
            n++;
            if (!oStall) begin
                done = 1;
                g = sb.pop_front();
                chk("rddata", oRdData, g.rd);
                chk("misalign", {31'h0, oMisalign}, {31'h0, g.mis});
                chk("buserr", {31'h0, oBusErr}, {31'h0, g.berr});
                chk("cycles", n, g.cyc);
                chk("valid_cycles", vc, g.vc);
            end else if (oBus_Valid) begin
                vc++;
                chk("bus_addr", oBus_Addr, {a[31:2], 2'b00});
                chk("bus_wren", {31'h0, oBus_WrEn}, {31'h0, we});
                chk("bus_ben", {28'h0, oBus_ByteEn}, {28'h0, ben_m(f3, a[1:0])});
                if (we) chk("bus_wdata", oBus_WrData, lane_m(f3, wd));
                iBus_Ready  = (dly >= 0) && (vc > dly);
                iBus_RdData = iBus_Ready ? rw : $urandom();
            end
        end
        iBus_Ready = 1'b0;
        if (!done) chk("done_bound", 32'h0, 32'h1);
    endtask

    task automatic idle1;
        @(negedge iClk);
        iReq = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", {31'h0, oBus_Valid}, 32'h0);
        chk("rst_rd", oRdData, 32'h0);
        @(negedge iClk);
        iRst_n = 1'b1;

        run(1'b1, 3'b010, 32'h0000_1006, 32'h1234_5678, 32'h0, 0, 32'h0);
        idle1();
        run(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00AB, 32'h0, 0, 32'h0);
        chk("sb_ben_const", {28'h0, ben_m(3'b000, 2'b10)}, 32'h4);
        idle1();
        run(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_0011, 3, 32'hFFFF_FF80);
        idle1();
        run(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_0011, 3, 32'h0000_0080);
        idle1();
        run(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0, 32'hFFFF_8001);
        idle1();
        run(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1, 32'h0000_8001);
        idle1();
        run(1'b0, 3'b001, 32'h0000_0201, 32'h0, 32'h8001_7FFF, 0, 32'h0);
        idle1();
        run(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, -1, 32'h0);
        idle1();

        @(negedge iClk);
        iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'b010; iAddr = 32'h0000_0300;
        repeat (3) @(negedge iClk);
        chk("pre_rst_valid", {31'h0, oBus_Valid}, 32'h1);
        #2 iRst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, oBus_Valid}, 32'h0);
        chk("arst_stall", {31'h0, oStall}, 32'h0);
        chk("arst_flags", {30'h0, oMisalign, oBusErr}, 32'h0);
        chk("arst_rd", oRdData, 32'h0);
        chk("arst_addr", oBus_Addr, 32'h0);
        chk("arst_ctl", {27'h0, oBus_WrEn, oBus_ByteEn}, 32'h0);
        chk("arst_wd", oBus_WrData, 32'h0);
        @(negedge iClk);
        iReq = 1'b0;
        @(negedge iClk);
        iRst_n = 1'b1;

        run(1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 0, 32'h0);
        idle1();
        run(1'b1, 3'b101, 32'h0000_0400, 32'h5555_AAAA, 32'h0, 0, 32'h0);
        idle1();
        run(1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 2, 32'h0);
        idle1();
        run(1'b1, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 1, 32'h0);
        run(1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        idle1();
        @(negedge iClk);
        chk("end_pulse", {30'h0, oMisalign, oBusErr}, 32'h0);
        chk("sb_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the DataPath memory port (address = ALU result, store data = rs2) and the data RAM bus.
- Turns one load/store request into a single aligned word-bus transaction with byte enables.
- Aligns and sign/zero-extends load data; stalls the single-cycle core until the access completes.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYC, 16, ACCESS-state cycles without iBus_Ready before the transaction is aborted (min 2).

Ports:
iClk  in  1  clock, rising edge
iRst_n  in  1  reset, asynchronous, active-low
iReq  in  1  memory instruction present (load or store); held until oStall low
iWe  in  1  1 = store, 0 = load
iFunct3  in  3  RV32I funct3 of the load/store
iAddr  in  32  byte address (ALU result)
iWrData  in  32  store data (rs2)
oRdData  out  32  extended load data; valid in the DONE cycle
oStall  out  1  hold PC and regfile write while high
oMisalign  out  1  fault pulse in DONE: misaligned address or illegal funct3
oBusErr  out  1  timeout pulse in DONE
oBus_Valid  out  1  bus request
iBus_Ready  in  1  slave accepts; read data valid in the same cycle
oBus_Addr  out  32  word address, {iAddr[31:2],2'b00}
oBus_WrEn  out  1  write transaction
oBus_ByteEn  out  4  byte lanes
oBus_WrData  out  32  lane-replicated store data
iBus_RdData  in  32  read word

Behaviour:
- Reset (async, iRst_n=0):
  - State goes to IDLE.
  - Every output is 0, including oBus_Valid, which drops immediately even mid-transaction.
  - All latches and the timeout counter clear.
- States:
  - IDLE -> ACCESS: iReq=1 and the access is legal.
  - IDLE -> DONE: iReq=1 and the access is illegal; no bus transaction, oMisalign=1.
  - ACCESS -> DONE: iBus_Ready=1, or the timeout counter reaches TIMEOUT_CYC-1 (oBusErr=1).
  - DONE -> IDLE: always.
- oStall = iReq & (state != DONE). It is combinational, so oStall is high in the first IDLE cycle of a request.
- Legality:
  - Byte ops (000, 100) are always aligned.
  - Half ops (001, 101) need iAddr[0]=0.
  - Word ops (010) need iAddr[1:0]=00.
  - Stores with funct3 of 100 or 101 are illegal.
  - funct3 of 011, 110 and 111 is illegal.
- On the IDLE->ACCESS transition, latch addr, we, funct3, byte enables and lane data. Bus outputs come only from these latches and stay stable until iBus_Ready.
- Byte enables and lane data:
  - SB: ByteEn = 4'b0001 << addr[1:0]; data = {4{wr[7:0]}}.
  - SH: ByteEn = 4'b0011 << {addr[1],1'b0}; data = {2{wr[15:0]}}.
  - SW: ByteEn = 4'b1111; data unchanged.
  - Loads: ByteEn shows the same lane pattern as the matching store; oBus_WrEn=0.
- Load extraction:
  - Shift iBus_RdData right by addr[1:0]*8.
  - LB: sign-extend bit 7. LBU: zero-extend bit 7. LH: sign-extend bit 15. LHU: zero-extend bit 15. LW: pass-through.
  - The result is registered on iBus_Ready.
  - oRdData is 0 after stores, faults and timeouts.
- Latency:
  - Ready on the first ACCESS cycle: 3 cycles total (IDLE, ACCESS, DONE); stall high for 2 cycles.
  - Each cycle of ready delay adds one cycle.
  - Fault: 2 cycles (IDLE, DONE).
- Timeout:
  - Counter is 0 on entering ACCESS and increments each ACCESS cycle without ready.
  - At TIMEOUT_CYC-1, oBus_Valid drops on the next edge and DONE asserts oBusErr.
  - Ready arriving in the same cycle as the limit counts as success.
- iReq falling during ACCESS is ignored: the transaction completes and DONE still pulses.
- iReq high in DONE starts no new access. The core advances in that cycle and the next request starts in IDLE.
- Fault and error pulses last exactly one cycle (DONE only).

Decomposition:
- Shared Define.sv gains:
  - funct3 constants `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW.
  - A typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t.
- One combinational sub-module, lsu_data_align:
  - Inputs: funct3, addr[1:0], wr data, rd word.
  - Outputs: ByteEn, lane data, extended load, legal flag.
- The FSM, latches and timeout counter stay in load_store_unit.

Test Plan:
1. SW addr 0x0000_1006 data 0x1234_5678 -> oMisalign pulses in cycle 2, oBus_Valid never rises, stall high for 1 cycle.
2. SB addr 0x0000_0102 data 0x0000_00AB with ready on the first ACCESS cycle -> oBus_Addr 0x100, ByteEn 0100, WrData 0xABABABAB, oStall high for cycles 1-2 and low in cycle 3.
3. LB addr 0x203 with bus word 0x80FF_0011 and ready delayed 3 cycles -> bus outputs stable throughout, oRdData 0xFFFF_FF80 in DONE; repeat with LBU -> 0x0000_0080.
4. LH addr 0x202 with word 0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LH addr 0x201 -> misalign fault.
5. LW addr 0x300 with iBus_Ready never asserted (TIMEOUT_CYC=16) -> oBus_Valid high for exactly 16 cycles, then oBusErr pulses, oRdData 0; then iRst_n low mid-ACCESS on a second LW -> oBus_Valid falls asynchronously and all outputs read 0.
6. funct3 011 load and funct3 101 store -> oMisalign pulse, no bus activity; back-to-back legal SW then LW -> two separate transactions with IDLE between DONE and the next ACCESS.
